// File: rtl/wb_pkg.sv
// Shared constants and select encodings for the write-back stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package wb_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int REG_ZERO = 0;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } wb_src_t;

    typedef enum logic {
        DST_RT = 1'b0,
        DST_RD = 1'b1
    } wb_dst_sel_t;

endpackage

// File: rtl/wb_select.sv
// Write-back source/destination muxing and commit-enable generation.
// Latency: purely combinational, zero cycles.
// Backpressure: none; wb_hold forces the commit enable low for the cycle.
module wb_select #(
    parameter int DATA_W = wb_pkg::DATA_W,
    parameter int ADDR_W = wb_pkg::ADDR_W
) (
    input  logic              wb_hold,
    input  logic              reg_write,
    input  logic              mem_to_reg,
    input  logic              reg_dst,
    input  logic [DATA_W-1:0] dato_mem,
    input  logic [DATA_W-1:0] alu,
    input  logic [ADDR_W-1:0] rd,
    input  logic [ADDR_W-1:0] rt,
    output logic [DATA_W-1:0] wb_data,
    output logic [ADDR_W-1:0] wb_dst,
    output logic              wr_en
);
    import wb_pkg::*;

    // Pick value and destination; the hold term is ANDed first so an
    // X/Z on the data/address fields under hold still yields wr_en = 0.
    always_comb begin
        wb_data = alu;
        wb_dst  = rt;
        if (wb_src_t'(mem_to_reg) == SRC_MEM) begin
            wb_data = dato_mem;
        end
        if (wb_dst_sel_t'(reg_dst) == DST_RD) begin
            wb_dst = rd;
        end
        wr_en = reg_write & ~wb_hold & (wb_dst != ADDR_W'(REG_ZERO));
    end

endmodule

// File: rtl/wb_regfile.sv
// 32-entry register file written from MEM/WB, two bypassed read ports, fwd record, write counter.
// Latency: write visible in storage 1 cycle later; read ports see it same cycle via bypass.
// Backpressure: none; wb_hold drops the write entirely for that cycle.
module wb_regfile #(
    parameter int DATA_W = wb_pkg::DATA_W,
    parameter int ADDR_W = wb_pkg::ADDR_W,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_hold,
    input  logic              reg_write,
    input  logic              mem_to_reg,
    input  logic              reg_dst,
    input  logic [DATA_W-1:0] dato_mem,
    input  logic [DATA_W-1:0] alu,
    input  logic [ADDR_W-1:0] rd,
    input  logic [ADDR_W-1:0] rt,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic              fwd_valid,
    output logic [ADDR_W-1:0] fwd_reg,
    output logic [DATA_W-1:0] fwd_data,
    output logic [CNT_W-1:0]  wr_count
);
    import wb_pkg::*;

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DATA_W-1:0] wb_data;
    logic [ADDR_W-1:0] wb_dst;
    logic              wr_en;

    wb_select #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_select (
        .wb_hold    (wb_hold),
        .reg_write  (reg_write),
        .mem_to_reg (mem_to_reg),
        .reg_dst    (reg_dst),
        .dato_mem   (dato_mem),
        .alu        (alu),
        .rd         (rd),
        .rt         (rt),
        .wb_data    (wb_data),
        .wb_dst     (wb_dst),
        .wr_en      (wr_en)
    );

    // Storage update; wr_en already excludes register 0, so entry 0 stays at its reset zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[wb_dst] <= wb_data;
        end
    end

    // Forwarding record and retired-write counter; record data holds when nothing commits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fwd_valid <= 1'b0;
            fwd_reg   <= '0;
            fwd_data  <= '0;
            wr_count  <= '0;
        end else begin
            fwd_valid <= wr_en;
            if (wr_en) begin
                fwd_reg  <= wb_dst;
                fwd_data <= wb_data;
                wr_count <= wr_count + CNT_W'(1);
            end
        end
    end

    // Read ports: zero register first, then same-cycle write bypass, then storage.
    always_comb begin
        rs_data = regs[rs_addr];
        rt_data = regs[rt_addr];
        if (rs_addr == ADDR_W'(REG_ZERO)) begin
            rs_data = '0;
        end else if (wr_en && rs_addr == wb_dst) begin
            rs_data = wb_data;
        end
        if (rt_addr == ADDR_W'(REG_ZERO)) begin
            rt_data = '0;
        end else if (wr_en && rt_addr == wb_dst) begin
            rt_data = wb_data;
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile, plus a CNT_W=4 instance for counter wrap.
// Latency: n/a.
// Backpressure: n/a.
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_hold;
    logic        reg_write;
    logic        mem_to_reg;
    logic        reg_dst;
    logic [31:0] dato_mem;
    logic [31:0] alu;
    logic [4:0]  rd;
    logic [4:0]  rt;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;

    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        fwd_valid;
    logic [4:0]  fwd_reg;
    logic [31:0] fwd_data;
    logic [31:0] wr_count;

    logic [31:0] s_rs_data;
    logic [31:0] s_rt_data;
    logic        s_fwd_valid;
    logic [4:0]  s_fwd_reg;
    logic [31:0] s_fwd_data;
    logic [3:0]  s_wr_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_regfile dut (
        .clk (clk), .rst (rst), .wb_hold (wb_hold), .reg_write (reg_write),
        .mem_to_reg (mem_to_reg), .reg_dst (reg_dst), .dato_mem (dato_mem),
        .alu (alu), .rd (rd), .rt (rt), .rs_addr (rs_addr), .rt_addr (rt_addr),
        .rs_data (rs_data), .rt_data (rt_data), .fwd_valid (fwd_valid),
        .fwd_reg (fwd_reg), .fwd_data (fwd_data), .wr_count (wr_count)
    );

    wb_regfile #(.CNT_W(4)) dut_small (
        .clk (clk), .rst (rst), .wb_hold (wb_hold), .reg_write (reg_write),
        .mem_to_reg (mem_to_reg), .reg_dst (reg_dst), .dato_mem (dato_mem),
        .alu (alu), .rd (rd), .rt (rt), .rs_addr (rs_addr), .rt_addr (rt_addr),
        .rs_data (s_rs_data), .rt_data (s_rt_data), .fwd_valid (s_fwd_valid),
        .fwd_reg (s_fwd_reg), .fwd_data (s_fwd_data), .wr_count (s_wr_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        wb_hold    = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        reg_dst    = 1'b0;
        dato_mem   = 32'h0;
        alu        = 32'h0;
        rd         = 5'd0;
        rt         = 5'd0;
    endtask

    task automatic drive_alu_rd(input logic [4:0] dst, input logic [31:0] val);
        wb_hold    = 1'b0;
        reg_write  = 1'b1;
        mem_to_reg = 1'b0;
        reg_dst    = 1'b1;
        alu        = val;
        dato_mem   = 32'h0;
        rd         = dst;
        rt         = 5'd0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_idle();
        rs_addr = 5'd5;
        rt_addr = 5'd5;
        #2;
        checks++;
        if (rs_data !== 32'h0 || wr_count !== 32'h0 || fwd_valid !== 1'b0 ||
            fwd_reg !== 5'd0 || fwd_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_initial rs=%h cnt=%h fv=%b fr=%h fd=%h, required all zero",
                     rs_data, wr_count, fwd_valid, fwd_reg, fwd_data);
        end
        tick();
        tick();
        rst = 1'b0;
        drive_alu_rd(5'd5, 32'h0000_1234);
        tick();
        drive_idle();
        checks++;
        if (rs_data !== 32'h0000_1234 || wr_count !== 32'd1) begin
            errors++;
            $display("FAIL reset_prewrite rs=%h cnt=%0d, required 00001234 and 1", rs_data, wr_count);
        end
        // Async reset mid-cycle: must act without a clock edge.
        rst = 1'b1;
        #1;
        checks++;
        if (rs_data !== 32'h0 || wr_count !== 32'h0 || fwd_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_async rs=%h cnt=%0d fv=%b, required 0 0 0", rs_data, wr_count, fwd_valid);
        end
        // A write presented while reset is held must be discarded.
        drive_alu_rd(5'd6, 32'h0000_6666);
        rs_addr = 5'd6;
        tick();
        rst = 1'b0;
        drive_idle();
        #1;
        checks++;
        if (rs_data !== 32'h0 || wr_count !== 32'h0) begin
            errors++;
            $display("FAIL reset_discard rs=%h cnt=%0d, required 0 and 0", rs_data, wr_count);
        end
    endtask

    task automatic test_alu_rd();
        drive_alu_rd(5'd8, 32'hDEAD_BEEF);
        tick();
        drive_idle();
        rs_addr = 5'd8;
        #1;
        checks++;
        if (rs_data !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL alu_rd_read got %h required deadbeef", rs_data);
        end
        checks++;
        if (fwd_valid !== 1'b1 || fwd_reg !== 5'd8 || fwd_data !== 32'hDEAD_BEEF || wr_count !== 32'd1) begin
            errors++;
            $display("FAIL alu_rd_fwd fv=%b fr=%0d fd=%h cnt=%0d, required 1 8 deadbeef 1",
                     fwd_valid, fwd_reg, fwd_data, wr_count);
        end
    endtask

    task automatic test_load_bypass();
        wb_hold    = 1'b0;
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        reg_dst    = 1'b0;
        rt         = 5'd9;
        rd         = 5'd8;
        dato_mem   = 32'hCAFE_F00D;
        alu        = 32'h1111_2222;
        rs_addr    = 5'd9;
        rt_addr    = 5'd9;
        #1;
        checks++;
        if (rs_data !== 32'hCAFE_F00D || rt_data !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL load_bypass rs=%h rt=%h required cafef00d on both", rs_data, rt_data);
        end
        tick();
        drive_idle();
        #1;
        checks++;
        if (rs_data !== 32'hCAFE_F00D || fwd_valid !== 1'b1 || fwd_reg !== 5'd9 || wr_count !== 32'd2) begin
            errors++;
            $display("FAIL load_commit rs=%h fv=%b fr=%0d cnt=%0d, required cafef00d 1 9 2",
                     rs_data, fwd_valid, fwd_reg, wr_count);
        end
        tick();
        checks++;
        if (fwd_valid !== 1'b0 || fwd_reg !== 5'd9 || fwd_data !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL fwd_hold fv=%b fr=%0d fd=%h, required 0 9 cafef00d", fwd_valid, fwd_reg, fwd_data);
        end
    endtask

    task automatic test_reg_zero();
        drive_alu_rd(5'd0, 32'hFFFF_FFFF);
        rs_addr = 5'd0;
        rt_addr = 5'd0;
        #1;
        checks++;
        if (rs_data !== 32'h0 || rt_data !== 32'h0) begin
            errors++;
            $display("FAIL reg0_bypass rs=%h rt=%h required 0", rs_data, rt_data);
        end
        tick();
        drive_idle();
        #1;
        checks++;
        if (rs_data !== 32'h0 || wr_count !== 32'd2 || fwd_valid !== 1'b0) begin
            errors++;
            $display("FAIL reg0_guard rs=%h cnt=%0d fv=%b, required 0 2 0", rs_data, wr_count, fwd_valid);
        end
    endtask

    task automatic test_hold();
        drive_alu_rd(5'd3, 32'h0000_00AA);
        tick();
        wb_hold   = 1'b1;
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        rd        = 5'd3;
        alu       = 32'h0000_0055;
        rs_addr   = 5'd3;
        #1;
        checks++;
        if (rs_data !== 32'h0000_00AA) begin
            errors++;
            $display("FAIL hold_nobypass got %h required 000000aa", rs_data);
        end
        tick();
        rd       = 'z;
        rt       = 'z;
        alu      = 'z;
        dato_mem = 'z;
        tick();
        drive_idle();
        #1;
        checks++;
        if (rs_data !== 32'h0000_00AA || wr_count !== 32'd3 || fwd_valid !== 1'b0) begin
            errors++;
            $display("FAIL hold_drop rs=%h cnt=%0d fv=%b, required 000000aa 3 0", rs_data, wr_count, fwd_valid);
        end
    endtask

    task automatic test_back_to_back();
        drive_alu_rd(5'd10, 32'h0000_0001);
        tick();
        drive_alu_rd(5'd11, 32'h0000_0002);
        rs_addr = 5'd10;
        rt_addr = 5'd11;
        #1;
        checks++;
        if (rs_data !== 32'h1 || rt_data !== 32'h2 || fwd_reg !== 5'd10) begin
            errors++;
            $display("FAIL b2b_mid rs=%h rt=%h fr=%0d, required 1 2 10", rs_data, rt_data, fwd_reg);
        end
        tick();
        drive_idle();
        #1;
        checks++;
        if (rs_data !== 32'h1 || rt_data !== 32'h2 || fwd_reg !== 5'd11 ||
            fwd_data !== 32'h2 || fwd_valid !== 1'b1 || wr_count !== 32'd5) begin
            errors++;
            $display("FAIL b2b_end rs=%h rt=%h fr=%0d fd=%h fv=%b cnt=%0d, required 1 2 11 2 1 5",
                     rs_data, rt_data, fwd_reg, fwd_data, fwd_valid, wr_count);
        end
    endtask

    task automatic test_counter_wrap();
        rst = 1'b1;
        #1;
        rst = 1'b0;
        drive_idle();
        for (int i = 0; i < 17; i++) begin
            drive_alu_rd(5'(1 + (i % 31)), 32'(i + 100));
            tick();
        end
        drive_idle();
        #1;
        checks++;
        if (s_wr_count !== 4'd1) begin
            errors++;
            $display("FAIL cnt_wrap got %0d required 1", s_wr_count);
        end
        checks++;
        if (wr_count !== 32'd17) begin
            errors++;
            $display("FAIL cnt_wide got %0d required 17", wr_count);
        end
    endtask

    initial begin
        rs_addr = 5'd0;
        rt_addr = 5'd0;
        test_reset();
        test_alu_rd();
        test_load_bypass();
        test_reg_zero();
        test_hold();
        test_back_to_back();
        test_counter_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
